// File: rtl/collision_scheduler.sv
// Collision lookup sequencer: walks the object table once per tick, one hit-map read per live slot.
// Optional build macro COLLISION_BOUNDS_CHECK_EN skips slots positioned outside the 160x120 playfield.
module collision_scheduler #(
    parameter int NUM_OBJ = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start_tick,
    input  logic [NUM_OBJ-1:0]   obj_valid,
    input  logic [NUM_OBJ-1:0]   obj_kind,
    input  logic [8*NUM_OBJ-1:0] obj_x,
    input  logic [7*NUM_OBJ-1:0] obj_y,
    output logic                 rd_en,
    output logic [14:0]          rd_addr,
    input  logic                 rd_data,
    output logic                 score_update,
    output logic                 health_update,
    output logic [NUM_OBJ-1:0]   hit_mask,
    output logic                 busy,
    output logic                 sweep_done,
    output logic                 overrun
);

    localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_OBJ - 1);

`ifdef COLLISION_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic               pending;
    logic [NUM_OBJ-1:0] snap_valid;
    logic [NUM_OBJ-1:0] snap_kind;
    logic [NUM_OBJ-1:0] work_mask;
    logic [7:0]         snap_x [NUM_OBJ];
    logic [6:0]         snap_y [NUM_OBJ];

    logic               is_last;
    logic [IW-1:0]      nxt_idx;
    logic               cur_live;
    logic               nxt_live;
    logic               in0_live;
    logic [14:0]        nxt_addr;
    logic [14:0]        in0_addr;
    logic [NUM_OBJ-1:0] mask_upd;
    logic               do_load;
    logic               do_adv;
    logic               do_fin;

    function automatic logic slot_live(input logic v, input logic [7:0] x, input logic [6:0] y);
        return v && (!BOUNDS || ((x < 8'd160) && (y < 7'd120)));
    endfunction

    function automatic logic [14:0] map_addr(input logic [7:0] x, input logic [6:0] y);
        return 15'(x) * 15'd120 + 15'(y);
    endfunction

    // rd_en is registered one cycle ahead so the strobe occupies the SCAN cycle and
    // rd_data arrives during WAIT; hence the look-ahead on the next slot.
    always_comb begin
        is_last  = (idx == LAST);
        nxt_idx  = is_last ? '0 : idx + 1'b1;
        cur_live = slot_live(snap_valid[idx], snap_x[idx], snap_y[idx]);
        nxt_live = slot_live(snap_valid[nxt_idx], snap_x[nxt_idx], snap_y[nxt_idx]);
        nxt_addr = map_addr(snap_x[nxt_idx], snap_y[nxt_idx]);
        in0_live = slot_live(obj_valid[0], obj_x[7:0], obj_y[6:0]);
        in0_addr = map_addr(obj_x[7:0], obj_y[6:0]);
        mask_upd = work_mask;
        mask_upd[idx] = rd_data;
        do_load  = ((state == IDLE) && start_tick) ||
                   ((state == DONE) && (pending || start_tick));
        do_adv   = ((state == SCAN) && !cur_live && !is_last) ||
                   ((state == WAIT) && !is_last);
        do_fin   = ((state == SCAN) && !cur_live && is_last) ||
                   ((state == WAIT) && is_last);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            idx           <= '0;
            pending       <= 1'b0;
            snap_valid    <= '0;
            snap_kind     <= '0;
            work_mask     <= '0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            score_update  <= 1'b0;
            health_update <= 1'b0;
            hit_mask      <= '0;
            busy          <= 1'b0;
            sweep_done    <= 1'b0;
            overrun       <= 1'b0;
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                snap_x[i] <= '0;
                snap_y[i] <= '0;
            end
        end else begin
            rd_en         <= 1'b0;
            score_update  <= 1'b0;
            health_update <= 1'b0;
            sweep_done    <= 1'b0;

            // A tick in DONE is served at once; only a tick on top of a pending one is lost.
            if (start_tick && (state != IDLE)) begin
                if (pending)
                    overrun <= 1'b1;
                else if (state != DONE)
                    pending <= 1'b1;
            end
            if (state == DONE)
                pending <= 1'b0;

            if (do_load) begin
                snap_valid <= obj_valid;
                snap_kind  <= obj_kind;
                for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                    snap_x[i] <= obj_x[8*i +: 8];
                    snap_y[i] <= obj_y[7*i +: 7];
                end
                work_mask <= '0;
                idx       <= '0;
                state     <= SCAN;
                busy      <= 1'b1;
                rd_en     <= in0_live;
                if (in0_live)
                    rd_addr <= in0_addr;
            end else if (do_adv) begin
                idx   <= nxt_idx;
                state <= SCAN;
                rd_en <= nxt_live;
                if (nxt_live)
                    rd_addr <= nxt_addr;
            end else if (do_fin) begin
                state      <= DONE;
                sweep_done <= 1'b1;
                hit_mask   <= (state == WAIT) ? mask_upd : work_mask;
            end else if (state == SCAN) begin
                state <= WAIT;
            end else if (state == DONE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end

            if (state == WAIT) begin
                work_mask <= mask_upd;
                if (rd_data) begin
                    score_update  <= ~snap_kind[idx];
                    health_update <= snap_kind[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: a timing model queues expected reads, pulses and sweep results.
module tb_collision_scheduler;

    localparam int N = 8;

    logic           clock = 1'b0;
    logic           resetn = 1'b0;
    logic           start_tick = 1'b0;
    logic [N-1:0]   obj_valid = '0;
    logic [N-1:0]   obj_kind = '0;
    logic [8*N-1:0] obj_x = '0;
    logic [7*N-1:0] obj_y = '0;
    logic           rd_en;
    logic [14:0]    rd_addr;
    logic           rd_data = 1'b0;
    logic           score_update;
    logic           health_update;
    logic [N-1:0]   hit_mask;
    logic           busy;
    logic           sweep_done;
    logic           overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t q_rd[$];
    ev_t q_upd[$];
    ev_t q_done[$];
    bit  hits[int];

    collision_scheduler #(.NUM_OBJ(N)) dut (
        .clock(clock), .resetn(resetn), .start_tick(start_tick),
        .obj_valid(obj_valid), .obj_kind(obj_kind), .obj_x(obj_x), .obj_y(obj_y),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .score_update(score_update), .health_update(health_update),
        .hit_mask(hit_mask), .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Hit-map RAM: synchronous read, data valid the cycle after rd_en.
    always @(posedge clock) begin
        cyc     <= cyc + 1;
        rd_data <= rd_en && hits.exists(int'(rd_addr));
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin : monitor
        ev_t e;
        if (resetn) begin
            if (rd_en) begin
                if (q_rd.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL read: unexpected strobe addr %0d, expected none (cycle %0d)", rd_addr, cyc);
                end else begin
                    e = q_rd.pop_front();
                    check("read cycle", cyc, e.cyc);
                    check("read addr", int'(rd_addr), e.val);
                end
            end
            if (score_update || health_update) begin
                if (q_upd.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL update: unexpected pulse score=%0b health=%0b, expected none (cycle %0d)",
                             score_update, health_update, cyc);
                end else begin
                    e = q_upd.pop_front();
                    check("update cycle", cyc, e.cyc);
                    check("update kind", int'({health_update, score_update}), e.val);
                end
            end
            if (sweep_done) begin
                if (q_done.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done: unexpected sweep_done mask %0h, expected none (cycle %0d)", hit_mask, cyc);
                end else begin
                    e = q_done.pop_front();
                    check("done cycle", cyc, e.cyc);
                    check("done mask", int'(hit_mask), e.val);
                end
            end
        end
    end

    // Expected events for a sweep whose first SCAN cycle is base+1; returns the DONE cycle.
    function automatic int model_sweep(input int base);
        int  k, mask, addr, x, y;
        bit  live;
        ev_t e;
        k = 1;
        mask = 0;
        for (int i = 0; i < N; i++) begin
            x = int'(obj_x[8*i +: 8]);
            y = int'(obj_y[7*i +: 7]);
            live = obj_valid[i];
`ifdef COLLISION_BOUNDS_CHECK_EN
            live = live && (x < 160) && (y < 120);
`endif
            if (live) begin
                addr = 120 * x + y;
                e.cyc = base + k; e.val = addr;
                q_rd.push_back(e);
                if (hits.exists(addr)) begin
                    mask |= (1 << i);
                    e.cyc = base + k + 2; e.val = obj_kind[i] ? 2 : 1;
                    q_upd.push_back(e);
                end
                k += 2;
            end else begin
                k += 1;
            end
        end
        e.cyc = base + k; e.val = mask;
        q_done.push_back(e);
        return base + k;
    endfunction

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic clear_objs();
        obj_valid = '0; obj_kind = '0; obj_x = '0; obj_y = '0;
        hits.delete();
    endtask

    task automatic set_obj(input int i, input logic k, input logic [7:0] x, input logic [6:0] y);
        obj_valid[i] = 1'b1;
        obj_kind[i]  = k;
        obj_x[8*i +: 8] = x;
        obj_y[7*i +: 7] = y;
    endtask

    task automatic pulse_tick();
        start_tick = 1'b1;
        step();
        start_tick = 1'b0;
    endtask

    task automatic run_sweep();
        void'(model_sweep(cyc));
        pulse_tick();
    endtask

    task automatic drain(input string name);
        int budget = 200;
        while ((q_rd.size() + q_upd.size() + q_done.size()) != 0 && budget > 0) begin
            step();
            budget--;
        end
        repeat (3) step();
        check({name, " missing events"}, q_rd.size() + q_upd.size() + q_done.size(), 0);
        q_rd.delete(); q_upd.delete(); q_done.delete();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int d;
        repeat (3) step();
        check("reset rd_en", int'(rd_en), 0);
        check("reset rd_addr", int'(rd_addr), 0);
        check("reset score", int'(score_update), 0);
        check("reset health", int'(health_update), 0);
        check("reset hit_mask", int'(hit_mask), 0);
        check("reset busy", int'(busy), 0);
        check("reset sweep_done", int'(sweep_done), 0);
        check("reset overrun", int'(overrun), 0);
        resetn = 1'b1;
        step();

        // single enemy, slot 2 at (10,5)
        clear_objs(); set_obj(2, 1'b0, 8'd10, 7'd5); hits[1205] = 1'b1;
        run_sweep();
        check("busy after tick", int'(busy), 1);
        drain("single");
        check("busy after sweep", int'(busy), 0);
        check("hit_mask held", int'(hit_mask), 8'h04);

        // mixed kinds, both hit
        clear_objs(); set_obj(0, 1'b0, 8'd1, 7'd2); set_obj(1, 1'b1, 8'd3, 7'd4);
        hits[122] = 1'b1; hits[364] = 1'b1;
        run_sweep();
        drain("mixed");

        // snapshot: x changes after the tick
        clear_objs(); set_obj(3, 1'b0, 8'd20, 7'd7); hits[2407] = 1'b1; hits[6007] = 1'b1;
        run_sweep();
        obj_x[8*3 +: 8] = 8'd50;
        drain("snapshot");

        // out-of-range slot
        clear_objs(); set_obj(0, 1'b0, 8'd200, 7'd5); hits[24005] = 1'b1;
        run_sweep();
        drain("bounds");

        // back-to-back ticks: second pending, third overruns
        clear_objs(); set_obj(0, 1'b0, 8'd1, 7'd1); set_obj(5, 1'b1, 8'd2, 7'd2);
        hits[121] = 1'b1; hits[242] = 1'b1;
        d = model_sweep(cyc);
        void'(model_sweep(d));
        pulse_tick();
        repeat (2) step();
        pulse_tick();
        repeat (2) step();
        pulse_tick();
        drain("back-to-back");
        check("overrun sticky", int'(overrun), 1);

        // reset during WAIT discards the sweep
        clear_objs(); set_obj(0, 1'b0, 8'd30, 7'd0); hits[3600] = 1'b1;
        run_sweep();
        step();
        resetn = 1'b0;
        #1;
        check("midreset rd_en", int'(rd_en), 0);
        check("midreset rd_addr", int'(rd_addr), 0);
        check("midreset score", int'(score_update), 0);
        check("midreset hit_mask", int'(hit_mask), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset overrun", int'(overrun), 0);
        q_rd.delete(); q_upd.delete(); q_done.delete();
        repeat (2) step();
        resetn = 1'b1;
        step();
        check("post-reset busy", int'(busy), 0);
        repeat (6) step();
        check("post-reset idle mask", int'(hit_mask), 0);

        // last slot projectile at the far corner
        clear_objs(); set_obj(7, 1'b1, 8'd159, 7'd119); hits[19199] = 1'b1;
        run_sweep();
        drain("last slot");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Sequences collision lookups for the Starflux playfield. On each game tick it walks a table of up to NUM_OBJ on-screen objects (enemies and enemy projectiles), reads the single-ported 160x120 hit-map memory once per live object, and emits registered score/health update pulses plus a per-object hit mask. It sits between the object-position registers and the hit-map RAM, and it is the only master of that RAM's read port. The score and health counters consume its outputs.

## Interface
Parameters:
- NUM_OBJ, 8: number of object slots (1..16).

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start_tick  in  1  one-cycle sweep request (2 Hz game tick).
- obj_valid  in  NUM_OBJ  slot i is live.
- obj_kind  in  NUM_OBJ  0 = enemy (hit gives score), 1 = enemy projectile (hit costs health).
- obj_x  in  8*NUM_OBJ  packed x, slot i at [8i+7:8i].
- obj_y  in  7*NUM_OBJ  packed y, slot i at [7i+6:7i].
- rd_en  out  1  hit-map read strobe.
- rd_addr  out  15  hit-map address = 120*x + y.
- rd_data  in  1  hit-map bit, valid the cycle after rd_en.
- score_update  out  1  one-cycle pulse per enemy hit.
- health_update  out  1  one-cycle pulse per projectile hit.
- hit_mask  out  NUM_OBJ  result of the last completed sweep.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse at end of sweep.
- overrun  out  1  sticky: a tick arrived while one was already pending.

## Operation
- States: IDLE, SCAN, WAIT, DONE.
- IDLE: start_tick=1 → snapshot obj_valid/kind/x/y into internal registers, clear working mask, idx=0, go to SCAN. Later input changes do not affect the sweep.
- SCAN: if slot idx is live (and in range, see Configuration), assert rd_en with rd_addr and go to WAIT. Otherwise skip: increment idx, or go to DONE if idx = NUM_OBJ-1.
- WAIT: sample rd_data into working mask bit idx. If it is 1, pulse score_update (kind 0) or health_update (kind 1) on the next cycle. Then increment idx or go to DONE.
- DONE: copy working mask to hit_mask, pulse sweep_done. Go to SCAN with a fresh snapshot if a tick is pending, else go to IDLE.
- Address arithmetic: 15-bit result of 120*x + y, with x zero-extended. The maximum value 30727 fits, so no truncation occurs.
- start_tick while busy: set a one-deep pending flag. A second tick while the flag is already set sets overrun, and the extra tick is dropped. overrun clears only on reset.
- start_tick in DONE counts as pending. It is served immediately.

## Timing
- Reset values: state IDLE, rd_en 0, rd_addr 0, score_update 0, health_update 0, hit_mask 0, busy 0, sweep_done 0, overrun 0, pending 0, idx 0.
- All outputs are registered.
- busy is 1 from the cycle after the accepted tick through the DONE cycle.
- Per slot: a skipped slot costs 1 cycle, a checked slot costs 2 cycles (SCAN, WAIT).
- Sweep latency from the tick edge to sweep_done: 1 + S + 2C cycles, where S = skipped slots and C = checked slots.
- rd_en is high for exactly one cycle per checked slot. rd_addr holds its value when rd_en=0.
- Update pulses go high one cycle after the WAIT cycle. Consecutive hits therefore produce pulses at least 2 cycles apart.
- Reset asserted mid-sweep returns the block to reset values immediately. The partial mask is discarded.

## Configuration
- COLLISION_BOUNDS_CHECK_EN defined: a slot with x ≥ 160 or y ≥ 120 is treated as not live. It is skipped in 1 cycle with no read, and its mask bit is 0.
- Not defined: every live slot is read at 120*x+y, even if out of range. Behaviour of the hit-map RAM for addresses ≥ 19200 is outside this block.

## Test plan
- Reset: resetn=0 mid-WAIT → all outputs 0 within the same cycle. After release, state is IDLE and busy=0.
- Single enemy: NUM_OBJ=8, only slot 2 live, kind 0, (10,5), rd_data=1 → rd_addr=1205 once. One score_update pulse, hit_mask=8'b00000100, sweep_done 1+7+2=10 cycles after the tick.
- Mixed kinds: slots 0 (kind 0) and 1 (kind 1) live, both hit → one score_update and one health_update, 2 cycles apart, with no other read strobes.
- Back-to-back ticks: tick, then a tick mid-sweep, then a third tick → the second sweep starts right after DONE. overrun=1 and only 2 sweep_done pulses occur.
- Snapshot: change obj_x of a live slot during busy → rd_addr uses the pre-tick value.
- Bounds: slot 0 at (200,5), live. With COLLISION_BOUNDS_CHECK_EN: no rd_en, mask bit 0. Without it: rd_addr=24005.
